biquad_coef_sequencer: RTL and testbench

//  Per-sample coefficient fetch sequencer for the biquad cascade. On each sample strobe it walks
//  NUM_STAGES stages and issues single Wishbone reads to the coefficient blockram's 64-bit read port.
//  It presents each fetched word to the biquad MAC over a valid/ready handshake.

---
 rtl/biquad_pkg.sv | 36 +++
 rtl/coef_addr_gen.sv | 87 ++++++++
 rtl/biquad_coef_sequencer.sv | 145 ++++++++++++++
 tb/tb_biquad_coef_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biquad_pkg.sv
// -----------------------------------------------------------------------------
// biquad_pkg
// Shared definitions for the biquad coefficient fetch path: sequencer FSM
// state encoding, coefficient word width, stage/word index widths and the
// field layout of the two 64-bit words each stage occupies:
//   w0 = {b0, b1, b2, a1}, w1 = {a2, 48'h0}
// -----------------------------------------------------------------------------
package biquad_pkg;

    localparam int unsigned COEF_W     = 64;
    localparam int unsigned STAGE_W    = 7;
    localparam int unsigned WORD_W     = 1;
    localparam int unsigned FIELD_W    = 16;
    localparam int unsigned BANK_SHIFT = 8;

    // Field positions (LSB) inside the coefficient words
    localparam int unsigned B0_LSB = 48;
    localparam int unsigned B1_LSB = 32;
    localparam int unsigned B2_LSB = 16;
    localparam int unsigned A1_LSB = 0;
    localparam int unsigned A2_LSB = 48;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_t;

    // Extract one 16-bit coefficient field from a fetched word
    function automatic logic [FIELD_W-1:0] coef_field(input logic [COEF_W-1:0] w,
                                                      input int unsigned        lsb);
        return w[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/coef_addr_gen.sv
// -----------------------------------------------------------------------------
// coef_addr_gen
// Stage/word counters for one coefficient sweep plus the blockram address.
// adr = base + stage*WORDS_PER_STAGE + word.
// Optional feature macro: COEF_BANK_SWAP_EN -- when defined, the bank select is
// captured on i_start and placed at address bit 8 (base = bank*256); when not
// defined, base is 0 and i_bank_sel is ignored.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_start        clear counters (and capture bank) for a new sweep
//   i_advance      step to the next word (never asserted on the last word)
//   i_bank_sel     bank for the sweep being started
//   o_stage/o_word current stage and word index
//   o_last         current word is the final word of the sweep
//   o_adr          blockram word address of the current word
// -----------------------------------------------------------------------------
module coef_addr_gen
    import biquad_pkg::*;
#(
    parameter int unsigned NUM_STAGES      = 8,
    parameter int unsigned WORDS_PER_STAGE = 2,
    parameter int unsigned ADR_W           = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_advance,
    input  logic               i_bank_sel,
    output logic [STAGE_W-1:0] o_stage,
    output logic [WORD_W-1:0]  o_word,
    output logic               o_last,
    output logic [ADR_W-1:0]   o_adr
);

    logic [STAGE_W-1:0] r_stage;
    logic [WORD_W-1:0]  r_word;
    logic [ADR_W-1:0]   w_base;
    logic [ADR_W-1:0]   w_offset;
    logic               w_word_wrap;

    assign w_word_wrap = (r_word == WORD_W'(WORDS_PER_STAGE - 1));

    // Word counter wraps into the next stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
            r_word  <= '0;
        end else if (i_start) begin
            r_stage <= '0;
            r_word  <= '0;
        end else if (i_advance) begin
            if (w_word_wrap) begin
                r_word  <= '0;
                r_stage <= r_stage + STAGE_W'(1);
            end else begin
                r_word  <= r_word + WORD_W'(1);
            end
        end
    end

`ifdef COEF_BANK_SWAP_EN
    logic r_bank;

    // Bank is frozen for the whole sweep; mid-sweep flips wait for the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank <= 1'b0;
        end else if (i_start) begin
            r_bank <= i_bank_sel;
        end
    end

    assign w_base = ADR_W'(r_bank) << BANK_SHIFT;
`else
    logic w_unused_bank;

    assign w_unused_bank = i_bank_sel;
    assign w_base        = '0;
`endif

    assign w_offset = ADR_W'(r_stage) * ADR_W'(WORDS_PER_STAGE) + ADR_W'(r_word);
    assign o_adr    = w_base + w_offset;
    assign o_stage  = r_stage;
    assign o_word   = r_word;
    assign o_last   = (r_stage == STAGE_W'(NUM_STAGES - 1)) && w_word_wrap;

endmodule

// File: rtl/biquad_coef_sequencer.sv
// -----------------------------------------------------------------------------
// biquad_coef_sequencer
// Per-sample coefficient fetch sequencer. Each accepted sample strobe walks
// all stages, issuing one single Wishbone read per 64-bit coefficient word and
// presenting each word to the MAC over a valid/ready handshake.
// Optional feature macro: COEF_BANK_SWAP_EN (bank select -> address bit 8).
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   sample_stb_i, bank_sel_i  sweep start pulse, bank for the next sweep
//   biquad_wb_*               Wishbone read master to the coefficient blockram
//   coef_data_o/stage_o/word_o, coef_valid_o, coef_ready_i
//                             held word + index, handshake to the MAC
//   sweep_done_o, busy_o      end-of-sweep pulse, sweep in progress
//   overrun_o, overrun_clr_i  sticky strobe-while-busy flag and its clear
// -----------------------------------------------------------------------------
module biquad_coef_sequencer
    import biquad_pkg::*;
#(
    parameter int unsigned NUM_STAGES      = 8,
    parameter int unsigned WORDS_PER_STAGE = 2,
    parameter int unsigned ADR_W           = 9
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               sample_stb_i,
    input  logic               bank_sel_i,
    output logic               biquad_wb_cyc_o,
    output logic               biquad_wb_stb_o,
    output logic [ADR_W-1:0]   biquad_wb_adr_o,
    input  logic [COEF_W-1:0]  biquad_wb_dat_i,
    input  logic               biquad_wb_ack_i,
    output logic [COEF_W-1:0]  coef_data_o,
    output logic [STAGE_W-1:0] coef_stage_o,
    output logic [WORD_W-1:0]  coef_word_o,
    output logic               coef_valid_o,
    input  logic               coef_ready_i,
    output logic               sweep_done_o,
    output logic               busy_o,
    output logic               overrun_o,
    input  logic               overrun_clr_i
);

    seq_state_t         r_state;
    logic               r_req;
    logic [COEF_W-1:0]  r_data;
    logic               r_valid;
    logic               r_done;
    logic               r_busy;
    logic               r_overrun;

    logic               w_start;
    logic               w_advance;
    logic               w_last;

    assign w_start   = (r_state == ST_IDLE) && sample_stb_i;
    assign w_advance = (r_state == ST_PRESENT) && coef_ready_i && !w_last;

    coef_addr_gen #(
        .NUM_STAGES      (NUM_STAGES),
        .WORDS_PER_STAGE (WORDS_PER_STAGE),
        .ADR_W           (ADR_W)
    ) u_addr_gen (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .i_start    (w_start),
        .i_advance  (w_advance),
        .i_bank_sel (bank_sel_i),
        .o_stage    (coef_stage_o),
        .o_word     (coef_word_o),
        .o_last     (w_last),
        .o_adr      (biquad_wb_adr_o)
    );

    // Sweep FSM; cyc/stb share one register so they can never disagree
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // A strobe while busy (DONE included) sets the flag even against a clear
            if (sample_stb_i && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr_i) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (sample_stb_i) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Drop stb right after ack so the blockram sees a gap between words
                    if (biquad_wb_ack_i) begin
                        r_data  <= biquad_wb_dat_i;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (coef_ready_i) begin
                        r_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign biquad_wb_cyc_o = r_req;
    assign biquad_wb_stb_o = r_req;
    assign coef_data_o     = r_data;
    assign coef_valid_o    = r_valid;
    assign sweep_done_o    = r_done;
    assign busy_o          = r_busy;
    assign overrun_o       = r_overrun;

endmodule

// File: tb/tb_biquad_coef_sequencer.sv
// -----------------------------------------------------------------------------
// tb_biquad_coef_sequencer
// Self-checking bench: a 512-word blockram model acking one cycle after stb,
// and a sweep-level reference model (expected address list, word index,
// handshake timing, sticky overrun flag) driven by randomized ready, stalls,
// bank selects and stray strobes. Honours COEF_BANK_SWAP_EN when defined.
// -----------------------------------------------------------------------------
module tb_biquad_coef_sequencer;

    localparam int NS    = 2;
    localparam int WPS   = 2;
    localparam int TOTAL = NS * WPS;
    localparam int SWEEP_BUDGET = 400;
`ifdef COEF_BANK_SWAP_EN
    localparam bit BANK_EN = 1'b1;
`else
    localparam bit BANK_EN = 1'b0;
`endif

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        sample_stb_i;
    logic        bank_sel_i;
    logic        biquad_wb_cyc_o;
    logic        biquad_wb_stb_o;
    logic [8:0]  biquad_wb_adr_o;
    logic [63:0] biquad_wb_dat_i;
    logic        biquad_wb_ack_i;
    logic [63:0] coef_data_o;
    logic [6:0]  coef_stage_o;
    logic        coef_word_o;
    logic        coef_valid_o;
    logic        coef_ready_i;
    logic        sweep_done_o;
    logic        busy_o;
    logic        overrun_o;
    logic        overrun_clr_i;

    logic [63:0] ram [0:511];
    logic        exp_ovr;
    int          n_checks;
    int          n_fail;

    biquad_coef_sequencer #(
        .NUM_STAGES      (NS),
        .WORDS_PER_STAGE (WPS),
        .ADR_W           (9)
    ) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .sample_stb_i    (sample_stb_i),
        .bank_sel_i      (bank_sel_i),
        .biquad_wb_cyc_o (biquad_wb_cyc_o),
        .biquad_wb_stb_o (biquad_wb_stb_o),
        .biquad_wb_adr_o (biquad_wb_adr_o),
        .biquad_wb_dat_i (biquad_wb_dat_i),
        .biquad_wb_ack_i (biquad_wb_ack_i),
        .coef_data_o     (coef_data_o),
        .coef_stage_o    (coef_stage_o),
        .coef_word_o     (coef_word_o),
        .coef_valid_o    (coef_valid_o),
        .coef_ready_i    (coef_ready_i),
        .sweep_done_o    (sweep_done_o),
        .busy_o          (busy_o),
        .overrun_o       (overrun_o),
        .overrun_clr_i   (overrun_clr_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Blockram: registered read, ack one cycle after stb, ack drops stb-cycle after
    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            biquad_wb_ack_i <= 1'b0;
            biquad_wb_dat_i <= '0;
        end else begin
            biquad_wb_ack_i <= biquad_wb_stb_o && !biquad_wb_ack_i;
            if (biquad_wb_stb_o && !biquad_wb_ack_i) begin
                biquad_wb_dat_i <= ram[biquad_wb_adr_o];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full sweep against the reference model; returns on the IDLE cycle after DONE
    task automatic run_sweep(input logic bank, input int rdy_pct, input int stall_k,
                             input int ovr_mode, input int ovr_k, input logic strobe_in_done);
        int   base;
        int   k_req;
        int   k_pres;
        int   stall_n;
        logic exp_req;
        logic exp_valid;
        logic nxt_req;
        logic nxt_valid;
        logic rdy;
        logic seen_valid;
        logic finished;
        logic ovr_fired;
        base       = (BANK_EN && bank) ? 256 : 0;
        k_req      = 0;
        k_pres     = 0;
        stall_n    = 0;
        exp_req    = 1'b1;
        exp_valid  = 1'b0;
        seen_valid = 1'b0;
        finished   = 1'b0;
        ovr_fired  = 1'b0;
        sample_stb_i = 1'b1;
        bank_sel_i   = bank;
        for (int n = 1; n <= SWEEP_BUDGET && !finished; n++) begin
            @(posedge wb_clk_i); #1;
            sample_stb_i  = 1'b0;
            overrun_clr_i = 1'b0;
            coef_ready_i  = 1'b0;
            bank_sel_i    = 1'($urandom_range(1, 0));
            check_eq("stb", 64'(biquad_wb_stb_o), 64'(exp_req));
            check_eq("cyc_eq_stb", 64'(biquad_wb_cyc_o), 64'(biquad_wb_stb_o));
            check_eq("valid", 64'(coef_valid_o), 64'(exp_valid));
            check_eq("busy", 64'(busy_o), 64'(k_pres < TOTAL));
            check_eq("sweep_done", 64'(sweep_done_o), 64'(k_pres == TOTAL));
            check_eq("overrun", 64'(overrun_o), 64'(exp_ovr));
            if (k_pres == TOTAL) begin
                finished = 1'b1;
            end else begin
                nxt_req   = exp_req;
                nxt_valid = exp_valid;
                if (biquad_wb_stb_o && biquad_wb_ack_i) begin
                    check_eq("adr", 64'(biquad_wb_adr_o), 64'(base + k_req));
                    k_req++;
                    nxt_req   = 1'b0;
                    nxt_valid = 1'b1;
                end
                if (coef_valid_o) begin
                    if (!seen_valid) begin
                        check_eq("valid_latency", 64'(n), 64'd3);
                        seen_valid = 1'b1;
                    end
                    check_eq("coef_data", coef_data_o, ram[base + k_pres]);
                    check_eq("coef_stage", 64'(coef_stage_o), 64'(k_pres / WPS));
                    check_eq("coef_word", 64'(coef_word_o), 64'(k_pres % WPS));
                end
                rdy = ($urandom_range(99, 0) < rdy_pct);
                if (coef_valid_o && k_pres == stall_k && stall_n < 5) begin
                    rdy = 1'b0;
                    stall_n++;
                end
                coef_ready_i = rdy;
                if (ovr_mode != 0 && !ovr_fired && coef_valid_o && k_pres == ovr_k) begin
                    sample_stb_i  = 1'b1;
                    overrun_clr_i = (ovr_mode == 2);
                    ovr_fired     = 1'b1;
                    exp_ovr       = 1'b1;
                end
                if (coef_valid_o && rdy) begin
                    k_pres++;
                    nxt_valid = 1'b0;
                    nxt_req   = (k_pres < TOTAL);
                end
                exp_req   = nxt_req;
                exp_valid = nxt_valid;
            end
        end
        if (!finished) check_eq("sweep_timeout", 64'd0, 64'd1);
        coef_ready_i = 1'b0;
        if (strobe_in_done) begin
            sample_stb_i = 1'b1;
            exp_ovr      = 1'b1;
        end
        @(posedge wb_clk_i); #1;
        sample_stb_i = 1'b0;
        check_eq("post_done_busy", 64'(busy_o), 64'd0);
        check_eq("post_done_cyc", 64'(biquad_wb_cyc_o), 64'd0);
        check_eq("done_one_cycle", 64'(sweep_done_o), 64'd0);
        check_eq("post_done_overrun", 64'(overrun_o), 64'(exp_ovr));
    endtask

    // Idle cycles, optionally pulsing the overrun clear on the first one
    task automatic idle(input int n, input logic do_clr);
        for (int i = 0; i < n; i++) begin
            overrun_clr_i = (i == 0) && do_clr;
            coef_ready_i  = 1'($urandom_range(1, 0));
            @(posedge wb_clk_i); #1;
            if (overrun_clr_i) exp_ovr = 1'b0;
            overrun_clr_i = 1'b0;
            check_eq("idle_busy", 64'(busy_o), 64'd0);
            check_eq("idle_cyc", 64'(biquad_wb_cyc_o), 64'd0);
            check_eq("idle_overrun", 64'(overrun_o), 64'(exp_ovr));
        end
        coef_ready_i = 1'b0;
    endtask

    initial begin
        logic r_bank;
        int   r_pct;
        int   r_stall;
        int   r_om;
        int   r_ok;
        logic r_sid;
        int   r_gap;
        n_checks      = 0;
        n_fail        = 0;
        exp_ovr       = 1'b0;
        wb_rst_i      = 1'b1;
        sample_stb_i  = 1'b0;
        bank_sel_i    = 1'b0;
        coef_ready_i  = 1'b0;
        overrun_clr_i = 1'b0;
        for (int i = 0; i < 512; i++) ram[i] = {$urandom, $urandom};

        repeat (3) @(posedge wb_clk_i);
        #1;
        check_eq("rst_cyc", 64'(biquad_wb_cyc_o), 64'd0);
        check_eq("rst_stb", 64'(biquad_wb_stb_o), 64'd0);
        check_eq("rst_adr", 64'(biquad_wb_adr_o), 64'd0);
        check_eq("rst_valid", 64'(coef_valid_o), 64'd0);
        check_eq("rst_data", coef_data_o, 64'd0);
        check_eq("rst_stage", 64'(coef_stage_o), 64'd0);
        check_eq("rst_word", 64'(coef_word_o), 64'd0);
        check_eq("rst_done", 64'(sweep_done_o), 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_overrun", 64'(overrun_o), 64'd0);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;

        // Ready high, then a 5-cycle stall on word 1 (back-to-back strobe after DONE)
        run_sweep(1'b0, 100, -1, 0, 0, 1'b0);
        run_sweep(1'b0, 100, 1, 0, 0, 1'b0);

        // Bank 1, stray strobe at stage 1 and in the DONE cycle, then clear
        run_sweep(1'b1, 100, -1, 1, WPS, 1'b1);
        idle(2, 1'b1);

        // Strobe together with clear while busy: set wins
        run_sweep(1'b0, 70, -1, 2, WPS, 1'b0);
        idle(1, 1'b1);

        // Reset while stb is up and the ack is still pending
        sample_stb_i = 1'b1;
        bank_sel_i   = 1'b0;
        @(posedge wb_clk_i); #1;
        sample_stb_i = 1'b0;
        check_eq("pre_rst_stb", 64'(biquad_wb_stb_o), 64'd1);
        wb_rst_i = 1'b1;
        #1;
        check_eq("async_rst_cyc", 64'(biquad_wb_cyc_o), 64'd0);
        check_eq("async_rst_stb", 64'(biquad_wb_stb_o), 64'd0);
        check_eq("async_rst_valid", 64'(coef_valid_o), 64'd0);
        check_eq("async_rst_busy", 64'(busy_o), 64'd0);
        exp_ovr = 1'b0;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        idle(1, 1'b0);
        run_sweep(1'b0, 100, -1, 0, 0, 1'b0);

        // Randomized sweeps
        for (int s = 0; s < 30; s++) begin
            r_bank  = 1'($urandom_range(1, 0));
            r_pct   = int'($urandom_range(100, 30));
            r_stall = ($urandom_range(3, 0) == 0) ? int'($urandom_range(TOTAL - 1, 0)) : -1;
            r_om    = int'($urandom_range(2, 0));
            r_ok    = int'($urandom_range(TOTAL - 1, 0));
            r_sid   = 1'($urandom_range(1, 0));
            r_gap   = int'($urandom_range(3, 0));
            run_sweep(r_bank, r_pct, r_stall, r_om, r_ok, r_sid);
            if (r_gap != 0) idle(r_gap, 1'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
